// File: rtl/aes_rs_pkg.sv
// Shared definitions for the aes_core_rs host adapter: FSM encoding and
// the byte counts of the AES-256 key and the AES block.
package aes_rs_pkg;

    localparam int AES256_KEY_BYTES = 32;
    localparam int AES_BLOCK_BYTES  = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_KEY   = 3'd1,
        S_PT    = 3'd2,
        S_START = 3'd3,
        S_WAIT  = 3'd4,
        S_TX    = 3'd5
    } state_e;

endpackage

// File: rtl/byte_serializer.sv
// Wide-word to byte-stream serializer. load_i captures a word (MSB byte
// first out) without raising valid; send_i raises valid. Valid, byte and
// last are all registered and only change on a handshake, load or send.
module byte_serializer #(
    parameter int NBYTES = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load_i,
    input  logic [NBYTES*8-1:0]   data_i,
    input  logic                  send_i,
    input  logic                  ready_i,
    output logic                  valid_o,
    output logic [7:0]            byte_o,
    output logic                  last_o
);

    localparam int W  = NBYTES * 8;
    localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CW-1:0] CNT_PEN = CW'(NBYTES - 2);

    logic [W-1:0]  sr_q, sr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          valid_q, valid_d;
    logic          last_q, last_d;
    logic          xfer_s;

    // Next-state for shift register, byte counter, valid and last flag.
    always_comb begin
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        last_d  = last_q;
        xfer_s  = valid_q & ready_i;

        if (load_i) begin
            sr_d   = data_i;
            cnt_d  = {CW{1'b0}};
            last_d = (NBYTES == 1) ? 1'b1 : 1'b0;
        end else if (xfer_s) begin
            sr_d   = {sr_q[W-9:0], 8'h00};
            cnt_d  = cnt_q + CW'(1);
            // last rises together with the byte it qualifies
            last_d = (cnt_q == CNT_PEN) ? 1'b1 : 1'b0;
        end else begin
            sr_d = sr_q;
        end

        if (send_i) begin
            valid_d = 1'b1;
        end else if (xfer_s && last_q) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Serializer state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q    <= {W{1'b0}};
            cnt_q   <= {CW{1'b0}};
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign valid_o = valid_q;
    assign byte_o  = sr_q[W-1 -: 8];
    assign last_o  = last_q;

endmodule

// File: rtl/aes_rs_host_adapter.sv
// Initiator for the aes_core_rs byte-load/start/done protocol. Takes one
// wide command, loads the key once per reset and the plaintext every time,
// pulses start, captures the result on done and streams it out bytewise.
module aes_rs_host_adapter
    import aes_rs_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [255:0] cmd_key,
    input  logic [127:0] cmd_pt,
    output logic         ld_key_valid,
    output logic [7:0]   ld_key_byte,
    input  logic         ld_key_ready,
    output logic         ld_state_valid,
    output logic [7:0]   ld_state_byte,
    input  logic         ld_state_ready,
    output logic         start,
    input  logic [127:0] core_state_out,
    input  logic         core_done,
    output logic         ct_valid,
    output logic [7:0]   ct_byte,
    output logic         ct_last,
    input  logic         ct_ready,
    output logic         key_locked,
    output logic         err_timeout
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);

    state_e        state_q, state_d;
    logic          key_locked_q, key_locked_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [TW-1:0] tmo_inc_s;
    logic          cmd_ready_q, start_q, err_timeout_q;

    logic cmd_hs_s;
    logic key_load_s, key_send_s, pt_load_s, pt_send_s, ct_load_s;
    logic expire_s;
    logic key_last_s, pt_last_s;
    logic key_done_s, pt_done_s, ct_done_s;

    assign cmd_hs_s   = cmd_valid & cmd_ready_q;
    assign key_done_s = ld_key_valid & ld_key_ready & key_last_s;
    assign pt_done_s  = ld_state_valid & ld_state_ready & pt_last_s;
    assign ct_done_s  = ct_valid & ct_ready & ct_last;
    assign tmo_inc_s  = tmo_cnt_q + TW'(1);

    // Next-state logic and serializer control strobes.
    always_comb begin
        state_d      = state_q;
        key_locked_d = key_locked_q;
        tmo_cnt_d    = tmo_cnt_q;
        key_load_s   = 1'b0;
        key_send_s   = 1'b0;
        pt_load_s    = 1'b0;
        pt_send_s    = 1'b0;
        ct_load_s    = 1'b0;
        expire_s     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_hs_s) begin
                    pt_load_s = 1'b1;
                    // the core cannot take a second key, so once locked the
                    // command key is dropped and only the block is loaded
                    if (!key_locked_q) begin
                        key_load_s = 1'b1;
                        key_send_s = 1'b1;
                        state_d    = S_KEY;
                    end else begin
                        pt_send_s  = 1'b1;
                        state_d    = S_PT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_KEY: begin
                if (key_done_s) begin
                    key_locked_d = 1'b1;
                    pt_send_s    = 1'b1;
                    state_d      = S_PT;
                end else begin
                    state_d = S_KEY;
                end
            end
            S_PT: begin
                if (pt_done_s) begin
                    state_d = S_START;
                end else begin
                    state_d = S_PT;
                end
            end
            S_START: begin
                tmo_cnt_d = {TW{1'b0}};
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                // done takes priority over an expiry in the same cycle;
                // the count includes the current cycle
                if (core_done) begin
                    ct_load_s = 1'b1;
                    tmo_cnt_d = {TW{1'b0}};
                    state_d   = S_TX;
                end else if (tmo_inc_s == TMO_LIMIT) begin
                    expire_s  = 1'b1;
                    tmo_cnt_d = {TW{1'b0}};
                    state_d   = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_inc_s;
                end
            end
            S_TX: begin
                if (ct_done_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_TX;
                end
            end
            default: begin
                tmo_cnt_d = {TW{1'b0}};
                state_d   = S_IDLE;
            end
        endcase
    end

    // FSM state, key lock, timeout counter and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            key_locked_q  <= 1'b0;
            tmo_cnt_q     <= {TW{1'b0}};
            cmd_ready_q   <= 1'b1;
            start_q       <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            key_locked_q  <= key_locked_d;
            tmo_cnt_q     <= tmo_cnt_d;
            cmd_ready_q   <= (state_d == S_IDLE);
            start_q       <= (state_d == S_START);
            err_timeout_q <= expire_s;
        end
    end

    byte_serializer #(.NBYTES(AES256_KEY_BYTES)) u_key_ser (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .load_i  (key_load_s),
        .data_i  (cmd_key),
        .send_i  (key_send_s),
        .ready_i (ld_key_ready),
        .valid_o (ld_key_valid),
        .byte_o  (ld_key_byte),
        .last_o  (key_last_s)
    );

    byte_serializer #(.NBYTES(AES_BLOCK_BYTES)) u_pt_ser (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .load_i  (pt_load_s),
        .data_i  (cmd_pt),
        .send_i  (pt_send_s),
        .ready_i (ld_state_ready),
        .valid_o (ld_state_valid),
        .byte_o  (ld_state_byte),
        .last_o  (pt_last_s)
    );

    byte_serializer #(.NBYTES(AES_BLOCK_BYTES)) u_ct_ser (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .load_i  (ct_load_s),
        .data_i  (core_state_out),
        .send_i  (ct_load_s),
        .ready_i (ct_ready),
        .valid_o (ct_valid),
        .byte_o  (ct_byte),
        .last_o  (ct_last)
    );

    assign cmd_ready   = cmd_ready_q;
    assign start       = start_q;
    assign key_locked  = key_locked_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_aes_rs_host_adapter.sv
// Self-checking bench for aes_rs_host_adapter with a stub aes_core_rs.
module tb_aes_rs_host_adapter;

    localparam int TMO = 20;
    localparam int M_NORMAL = 0;
    localparam int M_NEVER  = 1;
    localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [255:0] cmd_key = 256'h0;
    logic [127:0] cmd_pt = 128'h0;
    logic         ld_key_valid, ld_state_valid, start, ct_valid, ct_last, key_locked, err_timeout;
    logic [7:0]   ld_key_byte, ld_state_byte, ct_byte;
    logic         ld_key_ready = 1'b1, ld_state_ready = 1'b1, ct_ready = 1'b1;
    logic [127:0] core_state_out = 128'h0;
    logic         core_done = 1'b0;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [7:0]   exp_key_q[$];
    logic [7:0]   exp_pt_q[$];
    logic [7:0]   exp_ct_q[$];
    logic [255:0] model_key = 256'h0;
    logic         model_locked = 1'b0;
    logic         start_pending = 1'b0;
    logic         tmo_armed = 1'b0;
    logic         lat_check = 1'b0;
    int           exp_lat = 0;
    int           core_mode = M_NORMAL;
    int           core_dly = 1;
    logic         bp = 1'b0;
    int           cyc = 0;
    int           hs_cyc = 0;
    int           start_cyc = 0;
    int           key_seen = 0;
    int           pt_cnt = 0;
    logic [255:0] stub_key = 256'h0;
    logic [127:0] stub_pt = 128'h0;

    aes_rs_host_adapter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_key(cmd_key), .cmd_pt(cmd_pt),
        .ld_key_valid(ld_key_valid), .ld_key_byte(ld_key_byte), .ld_key_ready(ld_key_ready),
        .ld_state_valid(ld_state_valid), .ld_state_byte(ld_state_byte), .ld_state_ready(ld_state_ready),
        .start(start), .core_state_out(core_state_out), .core_done(core_done),
        .ct_valid(ct_valid), .ct_byte(ct_byte), .ct_last(ct_last), .ct_ready(ct_ready),
        .key_locked(key_locked), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // stand-in for the core's cipher on anything but the FIPS vector
    function automatic logic [127:0] toy_core(input logic [255:0] k, input logic [127:0] p);
        toy_core = {p[119:0], p[127:120]} ^ k[255:128] ^ ~k[127:0]
                 ^ 128'h0123456789abcdeffedcba9876543210;
    endfunction

    function automatic logic [31:0] outs();
        outs = {cmd_ready, ld_key_valid, ld_key_byte, ld_state_valid, ld_state_byte,
                start, ct_valid, ct_byte, ct_last, key_locked, err_timeout};
    endfunction

    // cycle counter
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // ready drivers: all high or random ~50%
    initial forever begin
        @(posedge clk);
        #1;
        if (bp) begin
            ld_key_ready   = 1'($urandom_range(0, 1));
            ld_state_ready = 1'($urandom_range(0, 1));
            ct_ready       = 1'($urandom_range(0, 1));
        end else begin
            ld_key_ready   = 1'b1;
            ld_state_ready = 1'b1;
            ct_ready       = 1'b1;
        end
    end

    // stub core: answers start after core_dly cycles, or never
    initial forever begin
        logic [127:0] res;
        @(negedge clk);
        if (rst_n && start && core_mode != M_NEVER) begin
            res = (stub_key == FIPS_KEY && stub_pt == FIPS_PT) ? FIPS_CT : toy_core(stub_key, stub_pt);
            repeat (core_dly) @(posedge clk);
            #1 core_done = 1'b1;
            core_state_out = res;
            @(posedge clk);
            #1 core_done = 1'b0;
            core_state_out = {$urandom, $urandom, $urandom, $urandom};
        end
    end

    // protocol monitor against the model queues
    initial begin
        logic pk_v, pk_r, ps_v, ps_r, pc_v, pc_r, pc_l, p_start, exp_err;
        logic [7:0] pk_b, ps_b, pc_b, e;
        pk_v = 1'b0; pk_r = 1'b0; ps_v = 1'b0; ps_r = 1'b0; pc_v = 1'b0; pc_r = 1'b0;
        pc_l = 1'b0; p_start = 1'b0; pk_b = 8'h0; ps_b = 8'h0; pc_b = 8'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                key_seen = 0;
                pk_v = 1'b0; ps_v = 1'b0; pc_v = 1'b0; p_start = 1'b0;
            end else begin
                check("start_excl", start & (ld_key_valid | ld_state_valid), 1'b0);
                check("key_locked", key_locked, (key_seen == 32));
                exp_err = tmo_armed && (cyc == start_cyc + TMO + 1);
                check("err_timeout", err_timeout, exp_err);
                if (exp_err) begin
                    check("tmo_cmd_ready", cmd_ready, 1'b1);
                    tmo_armed = 1'b0;
                end
                if (pk_v && !pk_r) check("key_hold", {ld_key_valid, ld_key_byte}, {1'b1, pk_b});
                if (ps_v && !ps_r) check("pt_hold", {ld_state_valid, ld_state_byte}, {1'b1, ps_b});
                if (pc_v && !pc_r) check("ct_hold", {ct_valid, ct_last, ct_byte}, {1'b1, pc_l, pc_b});
                if (ld_key_valid && ld_key_ready) begin
                    check("key_extra", exp_key_q.size() > 0, 1'b1);
                    if (exp_key_q.size() > 0) begin
                        e = exp_key_q.pop_front();
                        check("key_byte", ld_key_byte, e);
                    end
                    key_seen = key_seen + 1;
                    stub_key = {stub_key[247:0], ld_key_byte};
                end
                if (ld_state_valid && ld_state_ready) begin
                    check("pt_extra", exp_pt_q.size() > 0, 1'b1);
                    if (exp_pt_q.size() > 0) begin
                        e = exp_pt_q.pop_front();
                        check("pt_byte", ld_state_byte, e);
                    end
                    pt_cnt = pt_cnt + 1;
                    stub_pt = {stub_pt[119:0], ld_state_byte};
                end
                if (start) begin
                    check("start_pulse", p_start, 1'b0);
                    check("start_when", start_pending && exp_pt_q.size() == 0 && exp_key_q.size() == 0, 1'b1);
                    if (start_pending && lat_check) check("start_latency", cyc - hs_cyc, exp_lat);
                    start_pending = 1'b0;
                    start_cyc = cyc;
                    if (core_mode == M_NEVER) tmo_armed = 1'b1;
                end
                if (ct_valid && ct_ready) begin
                    check("ct_extra", exp_ct_q.size() > 0, 1'b1);
                    if (exp_ct_q.size() > 0) begin
                        e = exp_ct_q.pop_front();
                        check("ct_byte", ct_byte, e);
                        check("ct_last", ct_last, exp_ct_q.size() == 0);
                    end
                end
                if (cmd_valid && cmd_ready) begin
                    hs_cyc = cyc;
                    pt_cnt = 0;
                end
                pk_v = ld_key_valid; pk_r = ld_key_ready; pk_b = ld_key_byte;
                ps_v = ld_state_valid; ps_r = ld_state_ready; ps_b = ld_state_byte;
                pc_v = ct_valid; pc_r = ct_ready; pc_b = ct_byte; pc_l = ct_last;
                p_start = start;
            end
        end
    end

    task automatic send_cmd(input logic [255:0] k, input logic [127:0] p, input int mode, input int dly);
        logic [127:0] ct;
        logic got;
        core_mode = mode;
        core_dly  = dly;
        if (!model_locked) begin
            for (int i = 0; i < 32; i++) exp_key_q.push_back(k[255 - 8*i -: 8]);
            model_key    = k;
            model_locked = 1'b1;
            exp_lat      = 32 + 16 + 1;
        end else begin
            exp_lat = 16 + 1;
        end
        for (int i = 0; i < 16; i++) exp_pt_q.push_back(p[127 - 8*i -: 8]);
        if (mode != M_NEVER) begin
            ct = (model_key == FIPS_KEY && p == FIPS_PT) ? FIPS_CT : toy_core(model_key, p);
            for (int i = 0; i < 16; i++) exp_ct_q.push_back(ct[127 - 8*i -: 8]);
        end
        start_pending = 1'b1;
        lat_check     = !bp;
        @(posedge clk);
        #1 cmd_valid = 1'b1;
        cmd_key = k;
        cmd_pt  = p;
        got = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if (cmd_ready) got = 1'b1;
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        check("cmd_accept", got, 1'b1);
    endtask

    task automatic wait_idle(input string tag);
        logic done;
        done = 1'b0;
        for (int n = 0; n < 3000 && !done; n++) begin
            @(negedge clk);
            if (cmd_ready && !start_pending && !tmo_armed && exp_key_q.size() == 0
                && exp_pt_q.size() == 0 && exp_ct_q.size() == 0) done = 1'b1;
        end
        check(tag, done, 1'b1);
        check({tag, "_left"}, exp_key_q.size() + exp_pt_q.size() + exp_ct_q.size(), 0);
    endtask

    initial begin
        logic [255:0] rk;
        logic [127:0] rp;

        #12;
        check("reset_outs", outs(), 32'h8000_0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_outs", outs(), 32'h8000_0000);

        // FIPS-197 C.3, all readies high
        bp = 1'b0;
        send_cmd(FIPS_KEY, FIPS_PT, M_NORMAL, 5);
        wait_idle("fips_done");
        check("fips_locked", key_locked, 1'b1);

        // second command: key ignored, zero block under the first key
        for (int i = 0; i < 8; i++) rk[32*i +: 32] = $urandom;
        send_cmd(rk, 128'h0, M_NORMAL, 3);
        wait_idle("second_done");
        check("second_locked", key_locked, 1'b1);

        // backpressure with random blocks and core latency
        bp = 1'b1;
        for (int t = 0; t < 5; t++) begin
            rp = {$urandom, $urandom, $urandom, $urandom};
            send_cmd(rk, rp, M_NORMAL, $urandom_range(1, TMO - 1));
            wait_idle("bp_done");
        end

        // timeout: core never answers
        bp = 1'b0;
        send_cmd(rk, 128'h0123, M_NEVER, 1);
        wait_idle("tmo_done");

        // done coincident with expiry wins
        bp = 1'b1;
        send_cmd(rk, 128'hcafe_f00d, M_NORMAL, TMO);
        wait_idle("coinc_done");

        // reset after state byte 7
        bp = 1'b0;
        send_cmd(rk, {$urandom, $urandom, $urandom, $urandom}, M_NORMAL, 4);
        for (int n = 0; n < 200 && pt_cnt < 8; n++) @(negedge clk);
        check("pt_progress", pt_cnt >= 8, 1'b1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        exp_key_q.delete();
        exp_pt_q.delete();
        exp_ct_q.delete();
        model_locked  = 1'b0;
        start_pending = 1'b0;
        tmo_armed     = 1'b0;
        #1;
        check("async_reset_outs", outs(), 32'h8000_0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_unlocked", key_locked, 1'b0);

        // full key reload after reset
        send_cmd(FIPS_KEY, FIPS_PT, M_NORMAL, 7);
        wait_idle("reload_done");
        check("reload_locked", key_locked, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_rs_host_adapter.md
Name: aes_rs_host_adapter

Overview:
Initiator side of the aes_core_rs bytewise load/start/done protocol. Accepts one wide command (256-bit key plus 128-bit plaintext) and serialises it MSB-first onto the core's byte-load handshakes. It then pulses start, captures the 128-bit result on done, and streams the ciphertext out as 16 bytes over a valid/ready byte stream. It sits between the top-level register/bus front end and aes_core_rs.

Parameters:
TIMEOUT_CYCLES, 4095, max cycles allowed in S_WAIT for core_done before abort; counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  adapter idle, command accepted when cmd_valid&&cmd_ready
cmd_key  in  256  AES-256 key; byte 0 = cmd_key[255:248]
cmd_pt  in  128  plaintext; byte 0 = cmd_pt[127:120]
ld_key_valid  out  1  key byte valid to core
ld_key_byte  out  8  key byte
ld_key_ready  in  1  core accepts key byte
ld_state_valid  out  1  state byte valid to core
ld_state_byte  out  8  state byte
ld_state_ready  in  1  core accepts state byte
start  out  1  one-cycle start pulse to core
core_state_out  in  128  core ciphertext
core_done  in  1  core one-cycle completion pulse
ct_valid  out  1  ciphertext byte valid
ct_byte  out  8  ciphertext byte, MSB-first
ct_last  out  1  high with byte 15
ct_ready  in  1  downstream accepts byte
key_locked  out  1  key has been delivered to the core since reset
err_timeout  out  1  one-cycle pulse when S_WAIT times out

Behaviour:
- Reset values: all outputs 0 except cmd_ready = 1. FSM = S_IDLE, all counters 0, key_locked = 0.
- States: S_IDLE, S_KEY, S_PT, S_START, S_WAIT, S_TX.
- S_IDLE: cmd_ready = 1. On handshake:
  - Latch cmd_key into a key shift register and cmd_pt into a pt shift register.
  - Go to S_KEY if !key_locked, else go to S_PT.
  - When key_locked, cmd_key is ignored. The core never re-arms key loading, so a new key requires a reset.
- S_KEY: ld_key_valid = 1, ld_key_byte = key_sr[255:248].
  - On ld_key_valid&&ld_key_ready, shift key_sr left 8 bits and increment byte_cnt (5-bit).
  - On the transfer with byte_cnt == 31: set key_locked, clear byte_cnt, go to S_PT.
- S_PT: same pattern on the ld_state handshake, 16 bytes. After byte 15, go to S_START.
- S_START: start = 1 for exactly one cycle, then go to S_WAIT.
  - start is never high while any ld_*_valid is high; the core ignores loads while start is high.
- S_WAIT: the timeout counter increments each cycle.
  - core_done: capture core_state_out into ct_sr, clear the counter, go to S_TX.
  - counter == TIMEOUT_CYCLES with no done: pulse err_timeout, return to S_IDLE, no ciphertext is produced.
  - core_done on the same cycle as expiry: done wins.
- S_TX: ct_valid = 1, ct_byte = ct_sr[127:120], ct_last = (byte_cnt == 15).
  - On ct_valid&&ct_ready, shift and increment. After the last byte, go to S_IDLE.
  - ct_byte, ct_valid and ct_last are held stable while ct_ready is low.
- Valid outputs are registered and never drop without a handshake. Ready inputs may toggle freely. Back-to-back commands take a minimum of one idle cycle between the last ct byte and the next cmd_ready.
- Latency with all readies high:
  - first command: 32 + 16 + 1 cycles to start, core time, then 16 cycles of output;
  - later commands: 16 + 1 cycles to start.
- Reset mid-operation returns to S_IDLE immediately and clears key_locked. The core shares rst_n, so both sides resynchronise.
- Neither load handshake is ever asserted outside S_KEY or S_PT.

Decomposition:
- A shared package aes_rs_pkg holds:
  - FSM state encoding;
  - constants AES256_KEY_BYTES = 32 and AES_BLOCK_BYTES = 16.
- One natural sub-module is byte_serializer (parameterised byte count: load, valid/ready shift-out, last flag). It is instanced three times: key, pt, ct.

Test Plan:
- FIPS-197 C.3 vector:
  - stimulus: key 000102…1f, pt 00112233445566778899aabbccddeeff, all readies 1;
  - response: 32 key bytes 00..1f in order, then 16 pt bytes, one start pulse, then ct bytes 8e a2 b7 ca 51 67 45 bf ea fc 49 90 4b 49 60 89 with ct_last on 89.
- Second command with a different cmd_key and pt 00..00:
  - response: no ld_key_valid, key_locked stays 1, 16 state bytes;
  - the ciphertext matches AES-256 of pt 00..00 under the first key.
- Backpressure:
  - stimulus: ld_key_ready, ld_state_ready and ct_ready randomly low about 50% of cycles;
  - response: byte order and values are unchanged, outputs stay stable during stalls, each byte is transferred exactly once.
- Timeout:
  - stimulus: stub core never asserts core_done, TIMEOUT_CYCLES = 20;
  - response: err_timeout pulses exactly 20 cycles after S_WAIT entry, cmd_ready returns to 1, ct_valid is never asserted.
- Reset mid-S_PT:
  - stimulus: assert rst_n low after state byte 7;
  - response: all outputs reach their reset values asynchronously, key_locked = 0, the next command reloads all 32 key bytes.
- Core_done coincident with timeout expiry:
  - response: ciphertext is captured and streamed, err_timeout stays 0.
